// File: rtl/cipher_pkg.sv
// Shared definitions for the 128-bit, 12-round block cipher cores.
// Holds round constants, the half-word permutation and the FSM states.
package cipher_pkg;

    localparam int NUM_ROUNDS = 12;
    localparam int ROT = 21;

    typedef enum logic [2:0] {
        ST_LOAD,
        ST_KEYEXP,
        ST_R1,
        ST_R2,
        ST_R3,
        ST_DONE
    } state_t;

    function automatic logic [63:0] perm16(input logic [63:0] x);
        return {x[47:32], x[63:48], x[15:0], x[31:16]};
    endfunction

    function automatic logic [63:0] rotr(input logic [63:0] x);
        return (x >> ROT) | (x << (64 - ROT));
    endfunction

    function automatic logic [6:0] rc(input logic [3:0] i);
        logic [6:0] v;
        v = 7'h00;
        case (i)
            4'd0:    v = 7'h5A;
            4'd1:    v = 7'h34;
            4'd2:    v = 7'h73;
            4'd3:    v = 7'h66;
            4'd4:    v = 7'h57;
            4'd5:    v = 7'h35;
            4'd6:    v = 7'h71;
            4'd7:    v = 7'h62;
            4'd8:    v = 7'h5F;
            4'd9:    v = 7'h25;
            4'd10:   v = 7'h51;
            4'd11:   v = 7'h22;
            default: v = 7'h00;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/hw_dec_if.sv
// 32-bit memory-mapped slave bus shared by the cipher cores.
interface hw_dec_if;
    logic        address;
    logic        write;
    logic [31:0] writedata;
    logic        read;
    logic [31:0] readdata;
    logic        waitrequest;

    modport master (
        output address, write, writedata, read,
        input  readdata, waitrequest
    );

    modport slave (
        input  address, write, writedata, read,
        output readdata, waitrequest
    );
endinterface

// File: rtl/inv_sbox.sv
// Combinational 32-bit inverse S-box: eight parallel 4-bit inverse lookups.
module inv_sbox (
    input  logic [31:0] din,
    output logic [31:0] dout
);

    function automatic logic [3:0] inv4(input logic [3:0] n);
        logic [3:0] v;
        v = 4'h0;
        case (n)
            4'h0: v = 4'h5;
            4'h1: v = 4'hE;
            4'h2: v = 4'hF;
            4'h3: v = 4'h8;
            4'h4: v = 4'hC;
            4'h5: v = 4'h1;
            4'h6: v = 4'h2;
            4'h7: v = 4'hD;
            4'h8: v = 4'hB;
            4'h9: v = 4'h4;
            4'hA: v = 4'h6;
            4'hB: v = 4'h3;
            4'hC: v = 4'h0;
            4'hD: v = 4'h7;
            4'hE: v = 4'h9;
            4'hF: v = 4'hA;
            default: v = 4'h0;
        endcase
        return v;
    endfunction

    always_comb begin
        dout = '0;
        for (int i = 0; i < 8; i++)
            dout[i*4 +: 4] = inv4(din[i*4 +: 4]);
    end

endmodule

// File: rtl/hw_dec.sv
// Decryption core: load ciphertext and key, expand key, run inverse rounds,
// then serve the plaintext words back over the slave bus.
module hw_dec #(
    parameter int NUM_ROUNDS = cipher_pkg::NUM_ROUNDS
) (
    input  logic     clk,
    input  logic     reset,
    hw_dec_if.slave  bus
);
    import cipher_pkg::*;

    localparam logic [3:0] LAST = 4'(NUM_ROUNDS - 1);

    state_t       state;
    logic [127:0] text;
    logic [63:0]  kh, kl, a_q;
    logic [31:0]  sl_q, sh_q;
    logic [31:0]  sbox_in, sbox_out;
    logic [2:0]   wcnt;
    logic [1:0]   rcnt;
    logic [3:0]   cnt, rnd;
    logic         busy, wr_ok, rd_ok;
    logic [63:0]  lo_mix, lo_new;

    assign busy  = state inside {ST_KEYEXP, ST_R1, ST_R2, ST_R3};
    assign wr_ok = bus.write & ~busy;
    assign rd_ok = bus.read & ~busy;

    assign bus.waitrequest = busy;
    assign bus.readdata = (state == ST_DONE) ? text[{rcnt, 5'd0} +: 32] : '0;

    always_comb begin
        lo_mix = perm16(rotr(text[127:64] ^ text[63:0])) ^ kl;
        lo_new = lo_mix;
        lo_new[20:14] = lo_mix[20:14] - rc(rnd);
    end

    // One S-box instance: low word of A in R1, high word in R2.
    assign sbox_in = (state == ST_R2) ? a_q[63:32] : text[31:0];

    inv_sbox u_sbox (
        .din  (sbox_in),
        .dout (sbox_out)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_LOAD;
            text  <= '0;
            kh    <= '0;
            kl    <= '0;
            a_q   <= '0;
            sl_q  <= '0;
            sh_q  <= '0;
            wcnt  <= '0;
            rcnt  <= '0;
            cnt   <= '0;
            rnd   <= '0;
        end else begin
            unique case (state)
                ST_LOAD: begin
                    if (wr_ok) begin
                        if (!wcnt[2])
                            text[{wcnt[1:0], 5'd0} +: 32] <= bus.writedata;
                        else if (wcnt[1])
                            kh[{wcnt[0], 5'd0} +: 32] <= bus.writedata;
                        else
                            kl[{wcnt[0], 5'd0} +: 32] <= bus.writedata;
                        wcnt <= wcnt + 3'd1;
                        if (wcnt == 3'd7 && bus.address) begin
                            state <= ST_KEYEXP;
                            cnt   <= '0;
                        end
                    end
                end
                ST_KEYEXP: begin
                    kh  <= perm16(kl);
                    kl  <= perm16(kl) ^ kh;
                    cnt <= cnt + 4'd1;
                    if (cnt == LAST) begin
                        state <= ST_R1;
                        rnd   <= LAST;
                    end
                end
                ST_R1: begin
                    a_q          <= text[63:0];
                    sl_q         <= sbox_out;
                    text[63:0]   <= lo_new;
                    state        <= ST_R2;
                end
                ST_R2: begin
                    sh_q  <= sbox_out;
                    state <= ST_R3;
                end
                ST_R3: begin
                    text[127:64] <= {sh_q, sl_q} ^ kh;
                    kh <= kl ^ kh;
                    kl <= perm16(kh);
                    if (rnd == 4'd0) begin
                        state <= ST_DONE;
                    end else begin
                        rnd   <= rnd - 4'd1;
                        state <= ST_R1;
                    end
                end
                ST_DONE: begin
                    // A write aborts the readout and starts a new load.
                    if (wr_ok) begin
                        text[31:0] <= bus.writedata;
                        wcnt  <= 3'd1;
                        rcnt  <= '0;
                        state <= ST_LOAD;
                    end else if (rd_ok) begin
                        rcnt <= rcnt + 2'd1;
                        if (rcnt == 2'd3) begin
                            wcnt  <= '0;
                            state <= ST_LOAD;
                        end
                    end
                end
                default: state <= ST_LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_hw_dec.sv
// Round-trip bench for hw_dec against a forward-cipher reference model.
module tb_hw_dec;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    hw_dec_if bus ();

    hw_dec #(.NUM_ROUNDS(12)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [31:0] sb_in, sb_out;
    inv_sbox u_sb (.din(sb_in), .dout(sb_out));

    int checks = 0;
    int errors = 0;

    localparam logic [63:0] SBOX_T = 64'h2174_8FE3_DA09_B65C;
    localparam logic [6:0] RCT [12] = '{7'h5A, 7'h34, 7'h73, 7'h66,
                                        7'h57, 7'h35, 7'h71, 7'h62,
                                        7'h5F, 7'h25, 7'h51, 7'h22};

    function automatic logic [31:0] s32(input logic [31:0] x);
        logic [31:0] y;
        for (int i = 0; i < 8; i++)
            y[i*4 +: 4] = SBOX_T[{x[i*4 +: 4], 2'b00} +: 4];
        return y;
    endfunction

    function automatic logic [63:0] swp(input logic [63:0] x);
        return {x[47:32], x[63:48], x[15:0], x[31:16]};
    endfunction

    function automatic logic [63:0] rotl21(input logic [63:0] x);
        return {x[42:0], x[63:43]};
    endfunction

    function automatic logic [127:0] enc(input logic [127:0] k,
                                         input logic [127:0] p);
        logic [63:0] kh, kl, hi, lo, nk, s, t;
        kh = k[127:64];
        kl = k[63:0];
        hi = p[127:64];
        lo = p[63:0];
        for (int r = 0; r < 12; r++) begin
            nk = swp(kl);
            kl = nk ^ kh;
            kh = nk;
            s  = {s32(hi[63:32] ^ kh[63:32]), s32(hi[31:0] ^ kh[31:0])};
            t  = lo;
            t[20:14] = t[20:14] + RCT[r];
            hi = rotl21(swp(t ^ kl)) ^ s;
            lo = s;
        end
        return {hi, lo};
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_write(input logic [31:0] d, input logic a);
        bus.write     = 1'b1;
        bus.writedata = d;
        bus.address   = a;
        @(negedge clk);
    endtask

    task automatic write_words(input logic [127:0] c, input logic [127:0] k,
                               input logic last, input int from);
        for (int i = from; i < 8; i++)
            do_write(i < 4 ? c[i*32 +: 32] : k[(i-4)*32 +: 32],
                     i == 7 ? last : 1'b0);
        bus.write   = 1'b0;
        bus.address = 1'b0;
    endtask

    task automatic run_busy(output int n);
        n = 0;
        bus.write = 1'b0;
        #1;
        while (bus.waitrequest === 1'b1 && n < 200) begin
            n++;
            @(negedge clk);
            #1;
        end
    endtask

    task automatic read_words(input string tag, input logic [127:0] p,
                              input int cnt);
        for (int i = 0; i < cnt; i++) begin
            bus.read = 1'b1;
            #1;
            check($sformatf("%s_rd%0d", tag, i), bus.readdata, p[i*32 +: 32]);
            @(negedge clk);
        end
        bus.read = 1'b0;
    endtask

    task automatic round_trip(input string tag, input logic [127:0] k,
                              input logic [127:0] p);
        int n;
        write_words(enc(k, p), k, 1'b1, 0);
        run_busy(n);
        check({tag, "_busy"}, 32'(n), 32'd48);
        read_words(tag, p, 4);
        #1;
        check({tag, "_idle"}, bus.readdata, 32'h0);
    endtask

    initial begin
        int n;
        int bad;
        logic [31:0] x;
        logic [127:0] k, p, k2, p2;

        bus.address = 1'b0;
        bus.write = 1'b0;
        bus.read = 1'b0;
        bus.writedata = '0;
        reset = 1'b1;
        sb_in = '0;
        repeat (2) @(negedge clk);
        check("rst_wait", {31'd0, bus.waitrequest}, 32'd0);
        check("rst_rdata", bus.readdata, 32'h0);
        reset = 1'b0;

        sb_in = s32(32'h0);
        #1;
        check("sbox_zero", sb_out, 32'h0);
        sb_in = s32(32'hFFFF_FFFF);
        #1;
        check("sbox_ones", sb_out, 32'hFFFF_FFFF);
        bad = 0;
        for (int i = 0; i < 100000; i++) begin
            x = $urandom;
            sb_in = s32(x);
            #1;
            if (sb_out !== x) bad++;
        end
        check("sbox_rand_bad", 32'(bad), 32'd0);

        @(negedge clk);
        round_trip("zero", 128'h0, 128'h0);
        round_trip("vec", 128'h0F0E0D0C_0B0A0908_07060504_03020100,
                   128'h00112233_44556677_8899AABB_CCDDEEFF);

        // 8th write without the start qualifier: no busy period
        write_words(rnd128(), rnd128(), 1'b0, 0);
        #1;
        check("abort_wait0", {31'd0, bus.waitrequest}, 32'd0);
        @(negedge clk);
        check("abort_wait1", {31'd0, bus.waitrequest}, 32'd0);
        round_trip("after_abort", rnd128(), rnd128());

        // reset during round r=5
        write_words(enc(rnd128(), rnd128()), rnd128(), 1'b1, 0);
        repeat (31) @(negedge clk);
        check("pre_rst_busy", {31'd0, bus.waitrequest}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_wait", {31'd0, bus.waitrequest}, 32'd0);
        check("midrst_rdata", bus.readdata, 32'h0);
        reset = 1'b0;
        round_trip("after_rst", rnd128(), rnd128());

        // write in DONE after two reads, with a simultaneous read
        k = rnd128();
        p = rnd128();
        k2 = rnd128();
        p2 = rnd128();
        write_words(enc(k, p), k, 1'b1, 0);
        run_busy(n);
        check("wd_busy", 32'(n), 32'd48);
        read_words("wd_first", p, 2);
        bus.read = 1'b1;
        do_write(enc(k2, p2) >> 0, 1'b0);
        bus.read = 1'b0;
        bus.write = 1'b0;
        #1;
        check("wd_rdata0", bus.readdata, 32'h0);
        check("wd_wait0", {31'd0, bus.waitrequest}, 32'd0);
        write_words(enc(k2, p2), k2, 1'b1, 1);
        run_busy(n);
        check("wd2_busy", 32'(n), 32'd48);
        read_words("wd2", p2, 4);

        for (int i = 0; i < 4; i++)
            round_trip($sformatf("rand%0d", i), rnd128(), rnd128());

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
